// File: rtl/segment_pkg.sv
// Shared types and the hex glyph table for the multiplexed seven-segment scanner.
package segment_pkg;

    typedef struct packed {
        logic       enable;
        logic       dp;
        logic [3:0] value;
    } digit_t;

    // Glyphs in g..a bit order, active-high.
    localparam logic [6:0] SEGMENT_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {BLANK, ON, OFF} scan_state_e;

endpackage

// File: rtl/segment_font_decoder.sv
// Combinational digit to active-high {dp, g..a} pattern; a disabled digit decodes to all-off.
module segment_font_decoder
    import segment_pkg::*;
(
    input  digit_t      digit,
    output logic [7:0]  pattern
);

    always_comb begin
        pattern = '0;
        if (digit.enable) begin
            pattern = {digit.dp, SEGMENT_FONT[digit.value]};
        end
    end

endmodule

// File: rtl/segment_display_scanner.sv
// Self-timed seven-segment scanner with blanking, PWM brightness, output polarity control
// and a frame-synchronous double-buffered update handshake.
module segment_display_scanner
    import segment_pkg::*;
#(
    parameter int unsigned NUMBER_OF_DIGITS    = 4,
    parameter int unsigned CLOCK_DIVIDER       = 1000,
    parameter int unsigned BLANK_CYCLES        = 16,
    parameter int unsigned BRIGHTNESS_BITS     = 4,
    parameter bit          SEGMENT_ACTIVE_HIGH = 1'b1,
    parameter bit          DIGIT_ACTIVE_HIGH   = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  digit_t                      digits [0:NUMBER_OF_DIGITS-1],
    input  logic                        digits_valid,
    output logic                        digits_ready,
    input  logic [BRIGHTNESS_BITS-1:0]  brightness,
    output logic [7:0]                  segment_out,
    output logic [NUMBER_OF_DIGITS-1:0] digit_selector_out,
    output logic                        frame_start
);

    localparam int unsigned STEP =
        (CLOCK_DIVIDER - BLANK_CYCLES) / ((32'd1 << BRIGHTNESS_BITS) - 32'd1);
    localparam int unsigned SLOT_W  = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam int unsigned DIGIT_W = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
    localparam logic [SLOT_W-1:0]           SLOT_LAST  = SLOT_W'(CLOCK_DIVIDER - 1);
    localparam logic [DIGIT_W-1:0]          DIGIT_LAST = DIGIT_W'(NUMBER_OF_DIGITS - 1);
    localparam logic [7:0]                  SEG_INV    = {8{~SEGMENT_ACTIVE_HIGH}};
    localparam logic [NUMBER_OF_DIGITS-1:0] SEL_INV    = {NUMBER_OF_DIGITS{~DIGIT_ACTIVE_HIGH}};

    logic [SLOT_W-1:0]          slot_count_q;
    logic [DIGIT_W-1:0]         digit_index_q;
    logic [BRIGHTNESS_BITS-1:0] bright_q;
    logic [BRIGHTNESS_BITS-1:0] bright_eff;
    scan_state_e                state_q, state_d;
    logic [31:0]                slot_next;
    logic [31:0]                on_limit;

    digit_t active_q  [0:NUMBER_OF_DIGITS-1];
    digit_t pending_q [0:NUMBER_OF_DIGITS-1];
    logic   ready_q;

    logic                        slot_wrap, frame_end, transfer;
    digit_t                      cur_digit;
    logic [7:0]                  pattern;
    logic [7:0]                  seg_d, seg_q;
    logic [NUMBER_OF_DIGITS-1:0] sel_d, sel_q;
    logic                        frame_q;

    assign slot_wrap = (slot_count_q == SLOT_LAST);
    assign frame_end = slot_wrap && (digit_index_q == DIGIT_LAST);
    assign transfer  = digits_valid && ready_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_count_q  <= '0;
            digit_index_q <= '0;
            bright_q      <= '0;
            state_q       <= BLANK;
        end else begin
            state_q <= state_d;
            if (slot_count_q == '0) begin
                bright_q <= brightness;
            end
            if (slot_wrap) begin
                slot_count_q  <= '0;
                digit_index_q <= (digit_index_q == DIGIT_LAST) ? '0 : digit_index_q + 1'b1;
            end else begin
                slot_count_q <= slot_count_q + 1'b1;
            end
        end
    end

    // state_q describes the current slot_count; bright_q is only loaded at the
    // slot_count == 0 edge, so look through to the live input on that cycle.
    always_comb begin
        state_d    = state_q;
        bright_eff = (slot_count_q == '0) ? brightness : bright_q;
        slot_next  = 32'(slot_count_q) + 32'd1;
        on_limit   = BLANK_CYCLES + 32'(bright_eff) * STEP;
        if (slot_wrap) begin
            state_d = BLANK;
        end else if (slot_next < BLANK_CYCLES) begin
            state_d = BLANK;
        end else if (slot_next < on_limit) begin
            state_d = ON;
        end else begin
            state_d = OFF;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
                active_q[i]  <= '0;
                pending_q[i] <= '0;
            end
            ready_q <= 1'b1;
        end else begin
            if (frame_end) begin
                active_q <= pending_q;
            end
            // A transfer in the boundary cycle itself holds fresh data, so it keeps ready low.
            if (transfer) begin
                pending_q <= digits;
                ready_q   <= 1'b0;
            end else if (frame_end) begin
                ready_q <= 1'b1;
            end
        end
    end

    assign cur_digit = active_q[digit_index_q];

    segment_font_decoder u_font (
        .digit   (cur_digit),
        .pattern (pattern)
    );

    always_comb begin
        seg_d = '0;
        sel_d = '0;
        if (state_q == ON) begin
            seg_d                = pattern;
            sel_d[digit_index_q] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_q   <= SEG_INV;
            sel_q   <= SEL_INV;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d ^ SEG_INV;
            sel_q   <= sel_d ^ SEL_INV;
            frame_q <= (slot_count_q == '0) && (digit_index_q == '0);
        end
    end

    assign segment_out        = seg_q;
    assign digit_selector_out = sel_q;
    assign frame_start        = frame_q;
    assign digits_ready       = ready_q;

endmodule

// File: doc/segment_display_scanner.md
# segment_display_scanner

Self-timed multiplexed seven-segment driver, generalising the existing hex-to-segment display path. It takes per-digit hex value, decimal point and enable, and scans the digits internally at a parameterised rate. Scanning adds anti-ghosting blanking, PWM brightness, independent output polarities and an atomic frame-synchronous update handshake. It sits between register-mapped display data and the board pins.

## Interface
Parameters:
- NUMBER_OF_DIGITS, 4, digits scanned (≥1)
- CLOCK_DIVIDER, 1000, clock cycles per digit slot
- BLANK_CYCLES, 16, all-off cycles at the start of each slot (≥1)
- BRIGHTNESS_BITS, 4, width of brightness input; requires CLOCK_DIVIDER ≥ BLANK_CYCLES + 2**BRIGHTNESS_BITS − 1
- SEGMENT_ACTIVE_HIGH, 1'b1, segment_out polarity
- DIGIT_ACTIVE_HIGH, 1'b1, digit_selector_out polarity

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- digits  input  6 × NUMBER_OF_DIGITS (unpacked [0:N-1])  per digit: [5] enable, [4] dp, [3:0] hex value
- digits_valid  input  1  new digit set offered
- digits_ready  output  1  block can accept a digit set
- brightness  input  BRIGHTNESS_BITS  0 = dark, all-ones = full
- segment_out  output  8  {dp, g..a}, polarity per SEGMENT_ACTIVE_HIGH
- digit_selector_out  output  NUMBER_OF_DIGITS  one-hot digit select, polarity per DIGIT_ACTIVE_HIGH
- frame_start  output  1  one-cycle pulse at start of digit 0 slot

## Operation
- Counters: slot_count 0..CLOCK_DIVIDER−1, digit_index 0..N−1; digit_index advances when slot_count wraps, wraps N−1→0.
- STEP = (CLOCK_DIVIDER − BLANK_CYCLES) / (2**BRIGHTNESS_BITS − 1), integer localparam.
- brightness sampled into bright_q at slot_count == 0; held for the slot.
- Per-slot FSM: BLANK (slot_count < BLANK_CYCLES) → ON (while slot_count < BLANK_CYCLES + bright_q·STEP) → OFF (rest of slot) → BLANK on wrap. bright_q = 0 skips ON.
- ON: digit_selector_out asserts bit digit_index; segment_out = enable ? {dp, font(value)} : 0 (in active sense). BLANK/OFF: both outputs fully inactive.
- Font: 0‑F standard hex glyphs, g..a order (0 = 0111111, 1 = 0000110, … F = 1110001).
- Handshake: transfer on digits_valid && digits_ready → digits captured to pending buffer; digits_ready drops next cycle. On the last cycle of digit N−1's slot, pending copies to active buffer and digits_ready rises next cycle. Active buffer never changes mid-frame.
- valid without ready: ignored, no latching; sender holds.
- Transfer in the frame-boundary cycle itself: lands in pending, shown from the following frame.

## Timing
- Frame = N·CLOCK_DIVIDER cycles; ON window per slot = bright_q·STEP cycles.
- segment_out, digit_selector_out, frame_start registered: one cycle after the FSM/counter state that produces them.
- Reset (async assert, sync-released): slot_count = 0, digit_index = 0, active and pending buffers cleared, digits_ready = 1, frame_start = 0, segment_out and digit_selector_out at inactive level (all 0 if active-high, all 1 if active-low). Reset mid-frame drops pending data.
- First frame_start pulse: cycle 1 after reset release.

## Structure
- Package segment_pkg: digit_t packed struct {enable, dp, value[3:0]}, SEGMENT_FONT [16] constant, scan state enum {BLANK, ON, OFF}.
- Sub-module segment_font_decoder: combinational digit_t → 8-bit active-high pattern; polarity applied once at the output register.

## Test plan
Config N=4, CLOCK_DIVIDER=40, BLANK_CYCLES=4, BRIGHTNESS_BITS=2 (STEP=12), both polarities high.
- Reset → segment_out=0x00, digit_selector_out=0000, digits_ready=1; frame_start pulses every 160 cycles.
- Load {0x21,0x22,0x33,0x2F} (enable set, digit 2 dp), brightness=3 → from next frame, slot d shows selector 1<<d for 36 cycles. Patterns: 0x06, 0x5B, 0xCF, 0x71. 4 blank cycles precede each.
- brightness=1 → ON 12 cycles/slot; brightness=0 → outputs inactive whole frame. Change mid-slot takes effect next slot.
- Second valid while pending → digits_ready=0, no capture. Ready returns 1 cycle after frame boundary; displayed data switches exactly at digit 0.
- Enable bit clear on digit 1 → selector still asserted in its ON window, segment_out=0x00.
- Rerun with both polarities low → all outputs inverted, including reset values 0xFF / 1111. Assert reset mid-ON → outputs inactive immediately, pending cleared.
